// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizing, the twiddle-multiplier state encoding,
// and the coefficient index width.
package fft_pkg;

  localparam int FFT_N    = 16;
  localparam int FFT_MSB  = 16;
  localparam int FFT_FRAC = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOAD  = 2'd2,
    READY = 2'd3
  } state_t;

  // $clog2(n/2), kept at least one bit wide so tiny FFTs still get a legal index port.
  function automatic int idx_width(input int n);
    return (n / 2 <= 1) ? 1 : $clog2(n / 2);
  endfunction

endpackage

// File: rtl/cmul3.sv
// Three-multiplier complex multiply (a+jb)*(c+js) with a 3-register pipeline and valid bit.
// Uses precomputed c, c+s and c-s so only three products are needed.
module cmul3
  import fft_pkg::*;
#(
  parameter int MSB  = FFT_MSB,
  parameter int FRAC = FFT_FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [MSB-1:0] a,
  input  logic signed [MSB-1:0] b,
  input  logic signed [MSB-1:0] c,
  input  logic signed [MSB-1:0] cps,
  input  logic signed [MSB-1:0] cms,
  output logic                  out_valid,
  output logic signed [MSB-1:0] re,
  output logic signed [MSB-1:0] im
);

  // Wide enough that the product differences can never overflow before the shift.
  localparam int PW = 2 * MSB + 2;

  logic                  v1, v2;
  logic signed [MSB-1:0] a1, b1, c1, cps1, cms1;
  logic signed [MSB:0]   s1, s1_n;
  logic signed [PW-1:0]  m1, m2, m3;
  logic signed [PW-1:0]  m1_n, m2_n, m3_n;
  logic signed [PW-1:0]  d_re, d_im;
  logic signed [MSB-1:0] re_n, im_n;

  always_comb begin
    s1_n = (MSB+1)'(a) + (MSB+1)'(b);
    m1_n = PW'(c1) * PW'(s1);
    m2_n = PW'(b1) * PW'(cps1);
    m3_n = PW'(a1) * PW'(cms1);
    d_re = m1 - m2;
    d_im = m1 - m3;
    // Arithmetic shift, then plain truncation: results wrap rather than saturate.
    re_n = MSB'(d_re >>> FRAC);
    im_n = MSB'(d_im >>> FRAC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      s1        <= '0;
      c1        <= '0;
      cps1      <= '0;
      cms1      <= '0;
      m1        <= '0;
      m2        <= '0;
      m3        <= '0;
      re        <= '0;
      im        <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        a1   <= a;
        b1   <= b;
        s1   <= s1_n;
        c1   <= c;
        cps1 <= cps;
        cms1 <= cms;
      end
      if (v1) begin
        m1 <= m1_n;
        m2 <= m2_n;
        m3 <= m3_n;
      end
      if (v2) begin
        re <= re_n;
        im <= im_n;
      end
    end
  end

endmodule

// File: rtl/twiddle_mult.sv
// Twiddle-factor multiplier: loads one stage's coefficients from the mapper into a
// local buffer, then streams samples through the cmul3 datapath.
module twiddle_mult
  import fft_pkg::*;
#(
  parameter int N    = FFT_N,
  parameter int MSB  = FFT_MSB,
  parameter int FRAC = FFT_FRAC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [idx_width(N)-1:0]     stage,
  output logic                        map_start,
  output logic [idx_width(N)-1:0]     map_stage,
  input  logic                        map_we,
  input  logic                        map_valid,
  input  logic [idx_width(N)-1:0]     map_idx,
  input  logic signed [MSB-1:0]       map_c,
  input  logic signed [MSB-1:0]       map_cps,
  input  logic signed [MSB-1:0]       map_cms,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [MSB-1:0]       in_re,
  input  logic signed [MSB-1:0]       in_im,
  input  logic [idx_width(N)-1:0]     in_k,
  output logic                        out_valid,
  output logic signed [MSB-1:0]       out_re,
  output logic signed [MSB-1:0]       out_im,
  output logic                        busy
);

  localparam int DEPTH = N / 2;

  state_t state, state_n;

  logic signed [MSB-1:0] coef_c   [DEPTH];
  logic signed [MSB-1:0] coef_cps [DEPTH];
  logic signed [MSB-1:0] coef_cms [DEPTH];

  logic accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      map_stage <= '0;
    end else begin
      state <= state_n;
      if ((state == IDLE || state == READY) && start)
        map_stage <= stage;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = REQ;
      REQ:     state_n = LOAD;
      LOAD:    if (map_valid) state_n = READY;
      READY:   if (start) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    map_start = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      REQ: begin
        map_start = 1'b1;
        busy      = 1'b1;
      end
      LOAD:    busy     = 1'b1;
      READY:   in_ready = 1'b1;
      default: ;
    endcase
  end

  // Coefficient storage is deliberately left unreset; it is only meaningful after a LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD && map_we) begin
      coef_c[map_idx]   <= map_c;
      coef_cps[map_idx] <= map_cps;
      coef_cms[map_idx] <= map_cms;
    end
  end

  assign accept = in_valid && in_ready;

  cmul3 #(
    .MSB  (MSB),
    .FRAC (FRAC)
  ) u_cmul3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .a         (in_re),
    .b         (in_im),
    .c         (coef_c[in_k]),
    .cps       (coef_cps[in_k]),
    .cms       (coef_cms[in_k]),
    .out_valid (out_valid),
    .re        (out_re),
    .im        (out_im)
  );

endmodule
